// File: rtl/cell_input_conditioner_if.sv
// Button/inhibit inputs and press-event outputs of the cell input conditioner.
// master drives buttons and inhibit; slave is the conditioner itself.
interface cell_input_conditioner_if;
  logic       a, b, c, d, e, f, g, h, i;
  logic       inhibit;
  logic [8:0] cell_press;
  logic [3:0] cell_index;
  logic       any_press;
  logic       locked;

  modport master (
    output a, b, c, d, e, f, g, h, i,
    output inhibit,
    input  cell_press, cell_index,
    input  any_press, locked
  );

  modport slave (
    input  a, b, c, d, e, f, g, h, i,
    input  inhibit,
    output cell_press, cell_index,
    output any_press, locked
  );
endinterface

// File: rtl/cell_input_conditioner.sv
// Synchronizes and debounces nine cell buttons, then arbitrates
// one-cycle press pulses with a lock until every button is released.
module cell_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  cell_input_conditioner_if.slave bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, LOCK} state_e;

  logic [8:0]    raw;
  logic [8:0]    sync1_q, sync2_q;
  logic [8:0]    stable_q, stable_d;
  logic [8:0]    rise_q, rise_d;
  logic [CW-1:0] cnt_q [9];
  logic [CW-1:0] cnt_d [9];
  state_e        state_q, state_d;
  logic [8:0]    press_q, press_d;
  logic [3:0]    index_q, index_d;
  logic          any_q, any_d;
  logic [8:0]    gnt;
  logic [3:0]    gidx;

  assign raw = {bus.i, bus.h, bus.g, bus.f, bus.e,
                bus.d, bus.c, bus.b, bus.a};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Flip on the D-th consecutive disagreeing cycle; rise marks 0->1.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int n = 0; n < 9; n++) begin
      cnt_d[n] = '0;
      if (sync2_q[n] != stable_q[n]) begin
        if (cnt_q[n] == LAST) begin
          stable_d[n] = sync2_q[n];
          rise_d[n]   = sync2_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      rise_q   <= '0;
      for (int n = 0; n < 9; n++) cnt_q[n] <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int n = 0; n < 9; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Scan high to low so the lowest requester wins.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    for (int n = 8; n >= 0; n--) begin
      if (rise_q[n]) begin
        gnt     = '0;
        gnt[n]  = 1'b1;
        gidx    = 4'(n + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    press_d = '0;
    index_d = '0;
    any_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.inhibit && (rise_q != '0)) begin
          state_d = LOCK;
          press_d = gnt;
          index_d = gidx;
          any_d   = 1'b1;
        end
      end
      LOCK: begin
        if (stable_q == '0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      press_q <= '0;
      index_q <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      index_q <= index_d;
      any_q   <= any_d;
    end
  end

  assign bus.cell_press = press_q;
  assign bus.cell_index = index_q;
  assign bus.any_press  = any_q;
  assign bus.locked     = (state_q == LOCK);

endmodule

// File: tb/tb_cell_input_conditioner.sv
// Directed and random bench for cell_input_conditioner (DEBOUNCE_CYCLES=4)
// against a window-based behavioural model.
module tb_cell_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic [8:0] btn;
  logic inh;

  always #5 clk = ~clk;

  cell_input_conditioner_if cif();

  assign {cif.i, cif.h, cif.g, cif.f, cif.e,
          cif.d, cif.c, cif.b, cif.a} = btn;
  assign cif.inhibit = inh;

  cell_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif)
  );

  int errors = 0;
  int checks = 0;
  int tcount = 0;
  int npulse = 0;
  int t_pulse = 0;
  int t0;
  logic [3:0] last_idx;
  logic [8:0] last_press;

  // Model: raw history, synchronized history, stable levels, lock.
  logic [8:0] rh[$];
  logic [8:0] sq[$];
  logic [8:0] m_stable, m_rise, exp_press;
  logic [3:0] exp_idx;
  bit         m_locked;

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rh.delete();
    sq.delete();
    m_stable  = '0;
    m_rise    = '0;
    m_locked  = 1'b0;
    exp_press = '0;
    exp_idx   = '0;
  endtask

  task automatic model_step();
    logic [8:0] syn, low, nst;
    bit all;
    rh.push_back(btn);
    syn = (rh.size() >= 3) ? rh[rh.size()-3] : 9'd0;
    if (rh.size() > 3) void'(rh.pop_front());
    sq.push_back(syn);
    if (sq.size() > D) void'(sq.pop_front());
    low = m_rise & (~m_rise + 9'd1);
    exp_press = '0;
    exp_idx   = '0;
    if (m_locked) begin
      if (m_stable == '0) m_locked = 1'b0;
    end else if (!inh && low != '0) begin
      exp_press = low;
      for (int n = 0; n < 9; n++)
        if (low[n]) exp_idx = 4'(n + 1);
      m_locked = 1'b1;
    end
    nst = m_stable;
    if (sq.size() == D) begin
      for (int n = 0; n < 9; n++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++)
          if (sq[j][n] == m_stable[n]) all = 1'b0;
        if (all) nst[n] = ~m_stable[n];
      end
    end
    m_rise   = nst & ~m_stable;
    m_stable = nst;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    tcount++;
    if (reset) begin
      chk("rst_press", cif.cell_press, 9'd0);
      chk("rst_idx", 9'(cif.cell_index), 9'd0);
      chk("rst_any", 9'(cif.any_press), 9'd0);
      chk("rst_locked", 9'(cif.locked), 9'd0);
    end else begin
      chk("press", cif.cell_press, exp_press);
      chk("index", 9'(cif.cell_index), 9'(exp_idx));
      chk("any", 9'(cif.any_press), 9'(exp_press != '0));
      chk("locked", 9'(cif.locked), 9'(m_locked));
    end
    if (cif.any_press) begin
      npulse++;
      t_pulse    = tcount;
      last_idx   = cif.cell_index;
      last_press = cif.cell_press;
    end
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_press", cif.cell_press, 9'd0);
    chk("async_rst_locked", 9'(cif.locked), 9'd0);
    ticks(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    inh   = 1'b0;
    model_reset();
    ticks(3);
    reset = 1'b0;
    ticks(10);

    // Clean press of e
    npulse = 0;
    btn[4] = 1'b1;
    t0 = tcount + 1;
    ticks(10);
    chk_int("e_latency", t_pulse - t0, 6);
    chk_int("e_count", npulse, 1);
    chk("e_press", last_press, 9'b000010000);
    chk("e_index", 9'(last_idx), 9'd5);
    ticks(5);
    chk("e_held_locked", 9'(cif.locked), 9'd1);
    btn[4] = 1'b0;
    ticks(10);
    chk("e_released_locked", 9'(cif.locked), 9'd0);

    // Bounce on a
    npulse = 0;
    btn[0] = 1'b1; ticks(2);
    btn[0] = 1'b0; ticks(2);
    btn[0] = 1'b1; ticks(2);
    btn[0] = 1'b0; ticks(20);
    chk_int("bounce_count", npulse, 0);
    chk("bounce_locked", 9'(cif.locked), 9'd0);

    // Simultaneous c and g
    npulse = 0;
    btn[2] = 1'b1;
    btn[6] = 1'b1;
    ticks(12);
    chk_int("sim_count", npulse, 1);
    chk("sim_index", 9'(last_idx), 9'd3);
    btn[2] = 1'b0;
    ticks(12);
    chk_int("sim_g_held", npulse, 1);
    btn[6] = 1'b0;
    ticks(12);
    btn[6] = 1'b1;
    ticks(12);
    chk_int("sim_g_again", npulse, 2);
    chk("sim_g_index", 9'(last_idx), 9'd7);
    btn[6] = 1'b0;
    ticks(12);

    // Inhibit while i debounces
    npulse = 0;
    inh = 1'b1;
    btn[8] = 1'b1;
    ticks(12);
    inh = 1'b0;
    ticks(12);
    chk_int("inh_count", npulse, 0);
    btn[8] = 1'b0;
    ticks(12);

    // Lock with b pressed twice
    npulse = 0;
    btn[1] = 1'b1; ticks(10);
    btn[1] = 1'b0; ticks(14);
    btn[1] = 1'b1; ticks(30);
    chk_int("lock_count", npulse, 2);
    chk("lock_index", 9'(last_idx), 9'd2);
    btn[1] = 1'b0;
    ticks(12);

    // Reset mid-debounce of h
    npulse = 0;
    btn[7] = 1'b1;
    ticks(5);
    do_reset(2);
    t0 = tcount;
    ticks(12);
    chk_int("rst_h_latency", t_pulse - t0, 7);
    chk_int("rst_h_count", npulse, 1);
    chk("rst_h_index", 9'(last_idx), 9'd8);
    btn[7] = 1'b0;
    ticks(12);

    // Random bouncing buttons, inhibit and resets
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int n = 0; n < 9; n++) begin
        if (btn[n]) begin
          if ($urandom_range(0, 99) < 15) btn[n] = 1'b0;
        end else begin
          if ($urandom_range(0, 99) < 2) btn[n] = 1'b1;
        end
      end
      if ($urandom_range(0, 99) < 3) inh = ~inh;
      if ($urandom_range(0, 999) < 3)
        do_reset(int'($urandom_range(1, 3)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
